// File: rtl/ddr_mem_pkg.sv
// rtl/ddr_mem_pkg.sv - shared state encoding and latency-counter sizing for the DDR memory responder
package ddr_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RESP,
        RELEASE
    } memState_t;

    // The counter holds values from 0 up to the longer of the two latencies, never more.
    function automatic int latCntWidth(input int readLat, input int writeLat);
        int maxLat;
        maxLat = (readLat > writeLat) ? readLat : writeLat;
        return (maxLat < 2) ? 1 : $clog2(maxLat + 1);
    endfunction

    localparam int DEFAULT_LAT_CNT_WIDTH = latCntWidth(4, 2);

endpackage

// File: rtl/ddr_mem_responder_if.sv
// rtl/ddr_mem_responder_if.sv - cache-controller request/response bus for the DDR memory responder
interface ddr_mem_responder_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_LENGTH = 19
);

    logic                      CacheWriteEnIn;
    logic                      CacheReadEnIn;
    logic [DATA_WIDTH-1:0]     CacheDataIn;
    logic [ADDRESS_LENGTH-1:0] CacheAddressIn;
    logic                      CacheWriteReadyOut;
    logic                      CacheReadReadyOut;
    logic [DATA_WIDTH-1:0]     CacheDataOut;
    logic                      BusyOut;

    modport master (
        output CacheWriteEnIn,
        output CacheReadEnIn,
        output CacheDataIn,
        output CacheAddressIn,
        input  CacheWriteReadyOut,
        input  CacheReadReadyOut,
        input  CacheDataOut,
        input  BusyOut
    );

    modport slave (
        input  CacheWriteEnIn,
        input  CacheReadEnIn,
        input  CacheDataIn,
        input  CacheAddressIn,
        output CacheWriteReadyOut,
        output CacheReadReadyOut,
        output CacheDataOut,
        output BusyOut
    );

endinterface

// File: rtl/ddr_backing_ram.sv
// rtl/ddr_backing_ram.sv - single-port synchronous-read backing store, contents survive reset
module ddr_backing_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  writeEn,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_BITS) - 1];

    // One port: write when enabled, always register the addressed word for reading
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[addr] <= writeData;
        end
        readData <= mem[addr];
    end

endmodule

// File: rtl/ddr_mem_responder.sv
// rtl/ddr_mem_responder.sv - fixed-latency memory responder serving one cache read or write at a time
module ddr_mem_responder
    import ddr_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_LENGTH = 19,
    parameter int MEM_ADDR_BITS  = 16,
    parameter int READ_LATENCY   = 4,
    parameter int WRITE_LATENCY  = 2
) (
    input  logic                Clk,
    input  logic                ResetFlag,
    ddr_mem_responder_if.slave  bus
);

    localparam int CNT_W = latCntWidth(READ_LATENCY, WRITE_LATENCY);

    memState_t                state;
    memState_t                stateNext;
    logic [CNT_W-1:0]         latCnt;
    logic [CNT_W-1:0]         latCntNext;
    logic [MEM_ADDR_BITS-1:0] addrQ;
    logic [DATA_WIDTH-1:0]    writeDataQ;
    logic [DATA_WIDTH-1:0]    dataOutQ;
    logic                     isWriteQ;

    logic                     acceptWrite;
    logic                     acceptRead;
    logic                     lastWaitCycle;
    logic                     writeCommit;
    logic                     readDone;
    logic                     acceptedEnHeld;
    logic [MEM_ADDR_BITS-1:0] ramAddr;
    logic [DATA_WIDTH-1:0]    ramReadData;

    // A write wins over a simultaneous read; only IDLE accepts anything.
    assign acceptWrite    = (state == IDLE) && bus.CacheWriteEnIn;
    assign acceptRead     = (state == IDLE) && bus.CacheReadEnIn && !bus.CacheWriteEnIn;
    assign lastWaitCycle  = (latCnt == CNT_W'(1));
    assign writeCommit    = (state == WR_WAIT) && lastWaitCycle;
    assign readDone       = (state == RD_WAIT) && lastWaitCycle;
    assign acceptedEnHeld = isWriteQ ? bus.CacheWriteEnIn : bus.CacheReadEnIn;

    // The RAM sees the live address while idle so a read starts in its accept cycle;
    // afterwards the latched address keeps the read word stable until completion.
    assign ramAddr = (state == IDLE) ? bus.CacheAddressIn[MEM_ADDR_BITS-1:0] : addrQ;

    ddr_backing_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (MEM_ADDR_BITS)
    ) backingRam (
        .clk       (Clk),
        .writeEn   (writeCommit),
        .addr      (ramAddr),
        .writeData (writeDataQ),
        .readData  (ramReadData)
    );

    // State and latency counter registers
    always_ff @(posedge Clk or posedge ResetFlag) begin
        if (ResetFlag) begin
            state  <= IDLE;
            latCnt <= '0;
        end else begin
            state  <= stateNext;
            latCnt <= latCntNext;
        end
    end

    // Next-state and counter logic; the counter saturates at zero
    always_comb begin
        stateNext  = state;
        latCntNext = latCnt;
        unique case (state)
            IDLE: begin
                if (acceptWrite) begin
                    stateNext  = WR_WAIT;
                    latCntNext = CNT_W'(WRITE_LATENCY);
                end else if (acceptRead) begin
                    stateNext  = RD_WAIT;
                    latCntNext = CNT_W'(READ_LATENCY);
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (latCnt != '0) begin
                    latCntNext = latCnt - CNT_W'(1);
                end
                if (lastWaitCycle) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                stateNext = acceptedEnHeld ? RELEASE : IDLE;
            end
            RELEASE: begin
                if (!bus.CacheWriteEnIn && !bus.CacheReadEnIn) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext  = IDLE;
                latCntNext = '0;
            end
        endcase
    end

    // Latch the request at accept and the read word at completion
    always_ff @(posedge Clk or posedge ResetFlag) begin
        if (ResetFlag) begin
            addrQ      <= '0;
            writeDataQ <= '0;
            isWriteQ   <= 1'b0;
            dataOutQ   <= '0;
        end else begin
            if (acceptWrite || acceptRead) begin
                addrQ      <= bus.CacheAddressIn[MEM_ADDR_BITS-1:0];
                writeDataQ <= bus.CacheDataIn;
                isWriteQ   <= acceptWrite;
            end
            if (readDone) begin
                dataOutQ <= ramReadData;
            end
        end
    end

    assign bus.CacheWriteReadyOut = (state == RESP) && isWriteQ;
    assign bus.CacheReadReadyOut  = (state == RESP) && !isWriteQ;
    assign bus.CacheDataOut       = dataOutQ;
    assign bus.BusyOut            = (state != IDLE);

endmodule

// File: tb/tb_ddr_mem_responder.sv
// tb/tb_ddr_mem_responder.sv - self-checking bench for ddr_mem_responder
module tb_ddr_mem_responder;

    localparam int DW = 8;
    localparam int AL = 19;
    localparam int MB = 16;
    localparam int RL = 4;
    localparam int WL = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [DW-1:0]  model [int];
    logic [AL-1:0]  writtenQ [$];

    ddr_mem_responder_if #(.DATA_WIDTH(DW), .ADDRESS_LENGTH(AL)) busIf ();

    ddr_mem_responder #(
        .DATA_WIDTH     (DW),
        .ADDRESS_LENGTH (AL),
        .MEM_ADDR_BITS  (MB),
        .READ_LATENCY   (RL),
        .WRITE_LATENCY  (WL)
    ) dut (
        .Clk       (clk),
        .ResetFlag (rst),
        .bus       (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int memKey(input logic [AL-1:0] addr);
        return int'(addr[MB-1:0]);
    endfunction

    // One request from an idle DUT: accept at the first edge, ready expected
    // exactly lat edges later, enables either held (then RELEASE) or dropped.
    task automatic doReq(input logic wr, input logic rd, input logic [AL-1:0] addr,
                         input logic [DW-1:0] data, input bit hold, input int span,
                         input string tag);
        int lat;
        int pulses;
        int pulseAt;
        int otherPulses;
        int cycles;
        logic [DW-1:0] expData;
        lat     = wr ? WL : RL;
        expData = '0;
        if (!wr && model.exists(memKey(addr))) begin
            expData = model[memKey(addr)];
        end
        @(negedge clk);
        busIf.CacheWriteEnIn = wr;
        busIf.CacheReadEnIn  = rd;
        busIf.CacheAddressIn = addr;
        busIf.CacheDataIn    = data;
        @(negedge clk);
        check({tag, "/busy_after_accept"}, 32'(busIf.BusyOut), 32'd1);
        if (!hold) begin
            busIf.CacheWriteEnIn = 1'b0;
            busIf.CacheReadEnIn  = 1'b0;
            busIf.CacheAddressIn = AL'($urandom);
            busIf.CacheDataIn    = DW'($urandom);
        end
        pulses      = 0;
        pulseAt     = -1;
        otherPulses = 0;
        cycles      = (span > lat + 3) ? span : lat + 3;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            if (wr) begin
                if (busIf.CacheWriteReadyOut === 1'b1) begin
                    pulses++;
                    if (pulseAt < 0) pulseAt = k;
                end
                if (busIf.CacheReadReadyOut !== 1'b0) otherPulses++;
            end else begin
                if (busIf.CacheReadReadyOut === 1'b1) begin
                    pulses++;
                    if (pulseAt < 0) pulseAt = k;
                    check({tag, "/read_data"}, 32'(busIf.CacheDataOut), 32'(expData));
                end
                if (busIf.CacheWriteReadyOut !== 1'b0) otherPulses++;
            end
        end
        check({tag, "/ready_pulses"}, 32'(pulses), 32'd1);
        check({tag, "/ready_latency"}, 32'(pulseAt), 32'(lat));
        check({tag, "/other_ready"}, 32'(otherPulses), 32'd0);
        if (!wr) begin
            check({tag, "/data_held"}, 32'(busIf.CacheDataOut), 32'(expData));
        end
        if (hold) begin
            check({tag, "/release_busy"}, 32'(busIf.BusyOut), 32'd1);
            busIf.CacheWriteEnIn = 1'b0;
            busIf.CacheReadEnIn  = 1'b0;
            @(negedge clk);
        end
        check({tag, "/idle_after"}, 32'(busIf.BusyOut), 32'd0);
        if (wr) begin
            model[memKey(addr)] = data;
            writtenQ.push_back(addr);
        end
    endtask

    initial begin
        logic [AL-1:0] a;
        logic [DW-1:0] d;
        bit            h;
        int            pulses;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        busIf.CacheWriteEnIn = 1'b0;
        busIf.CacheReadEnIn  = 1'b0;
        busIf.CacheAddressIn = '0;
        busIf.CacheDataIn    = '0;

        repeat (3) @(negedge clk);
        check("reset/busy", 32'(busIf.BusyOut), 32'd0);
        check("reset/wr_ready", 32'(busIf.CacheWriteReadyOut), 32'd0);
        check("reset/rd_ready", 32'(busIf.CacheReadReadyOut), 32'd0);
        check("reset/data_out", 32'(busIf.CacheDataOut), 32'd0);
        rst = 1'b0;

        // Directed: held write, then plain read of the same address
        doReq(1'b1, 1'b0, 19'h00123, 8'hA5, 1'b1, 0, "wr_123_hold");
        doReq(1'b0, 1'b1, 19'h00123, 8'h00, 1'b0, 0, "rd_123");

        // Simultaneous enables are a write only
        doReq(1'b1, 1'b1, 19'h00010, 8'h3C, 1'b0, 0, "dual_010");
        doReq(1'b0, 1'b1, 19'h00010, 8'h00, 1'b0, 0, "rd_010");

        // Upper address bits alias onto the same word
        doReq(1'b1, 1'b0, 19'h40010, 8'h77, 1'b0, 0, "wr_40010");
        doReq(1'b0, 1'b1, 19'h00010, 8'h00, 1'b0, 0, "rd_alias_010");

        // Enables held for 20 cycles still give one pulse each
        doReq(1'b0, 1'b1, 19'h00123, 8'h00, 1'b1, 20, "rd_hold20");
        doReq(1'b1, 1'b0, 19'h00200, 8'h81, 1'b1, 20, "wr_hold20");

        // Reset one cycle into a write aborts it and leaves memory untouched
        doReq(1'b1, 1'b0, 19'h00020, 8'h5A, 1'b0, 0, "wr_020_prior");
        @(negedge clk);
        busIf.CacheWriteEnIn = 1'b1;
        busIf.CacheAddressIn = 19'h00020;
        busIf.CacheDataIn    = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort/busy", 32'(busIf.BusyOut), 32'd0);
        check("abort/wr_ready", 32'(busIf.CacheWriteReadyOut), 32'd0);
        check("abort/rd_ready", 32'(busIf.CacheReadReadyOut), 32'd0);
        check("abort/data_out", 32'(busIf.CacheDataOut), 32'd0);
        busIf.CacheWriteEnIn = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busIf.CacheWriteReadyOut !== 1'b0 || busIf.CacheReadReadyOut !== 1'b0) pulses++;
        end
        check("abort/no_pulse", 32'(pulses), 32'd0);
        rst = 1'b0;
        doReq(1'b0, 1'b1, 19'h00020, 8'h00, 1'b0, 0, "rd_020_after_abort");

        // Randomized traffic against the reference memory
        for (int i = 0; i < 16; i++) begin
            h = 1'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                a = AL'($urandom);
                d = DW'($urandom);
                doReq(1'b1, 1'($urandom), a, d, h, 0, $sformatf("rand%0d_wr", i));
            end else begin
                a = writtenQ[$urandom_range(0, writtenQ.size() - 1)];
                a[AL-1:MB] = (AL - MB)'($urandom);
                doReq(1'b0, 1'b1, a, DW'($urandom), h, 0, $sformatf("rand%0d_rd", i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
